// File: rtl/audio_pkg.sv
// Shared types and frame geometry for the I2S transmit path.
// A frame is 64 sclk slots: 32 for the left word, 32 for the right word.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } tx_state_t;

  localparam int SLOTS     = 64;
  localparam int SLOT_BITS = 32;
  localparam int SLOT_W    = $clog2(SLOTS);

  function automatic int frame_cycles(input int mclk_div, input int bclk_ratio);
    return mclk_div * bclk_ratio * SLOTS;
  endfunction

endpackage

// File: rtl/audio_clk_phase.sv
// Free-running frame counter and the mclk/sclk/lrclk levels derived from it.
// Outputs are registered from the next-state values so pins stay glitch-free.
module audio_clk_phase
  import audio_pkg::*;
#(
  parameter int MCLK_DIV   = 8,
  parameter int BCLK_RATIO = 4,
  parameter int CNT_W      = $clog2(MCLK_DIV * BCLK_RATIO * SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             running,
  input  logic             go,
  output logic [CNT_W-1:0] cnt,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk,
  output logic             sclk_fall,
  output logic             frame0
);

  localparam int SCLK_DIV = MCLK_DIV * BCLK_RATIO;
  localparam int FRAME    = frame_cycles(MCLK_DIV, BCLK_RATIO);
  localparam int MPH_W    = $clog2(MCLK_DIV);
  localparam int SPH_W    = $clog2(SCLK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [MPH_W-1:0] MPH_LAST = MPH_W'(MCLK_DIV - 1);
  localparam logic [MPH_W-1:0] MPH_HALF = MPH_W'(MCLK_DIV / 2);
  localparam logic [SPH_W-1:0] SPH_LAST = SPH_W'(SCLK_DIV - 1);
  localparam logic [SPH_W-1:0] SPH_HALF = SPH_W'(SCLK_DIV / 2);

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [MPH_W-1:0]  mph_reg, mph_next;
  logic [SPH_W-1:0]  sph_reg, sph_next;
  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic              mclk_reg, sclk_reg, lrclk_reg;

  // Phase counters run in lockstep with the frame counter; entering a run
  // (or being idle) forces every phase back to zero.
  always_comb begin
    cnt_next  = '0;
    mph_next  = '0;
    sph_next  = '0;
    slot_next = '0;
    if (go && running) begin
      cnt_next  = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      mph_next  = (mph_reg == MPH_LAST) ? '0 : mph_reg + 1'b1;
      sph_next  = (sph_reg == SPH_LAST) ? '0 : sph_reg + 1'b1;
      slot_next = (sph_reg == SPH_LAST) ? slot_reg + 1'b1 : slot_reg;
    end
  end

  assign sclk_fall = go && (sph_next == '0);
  assign frame0    = go && (cnt_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      mph_reg   <= '0;
      sph_reg   <= '0;
      slot_reg  <= '0;
      mclk_reg  <= 1'b0;
      sclk_reg  <= 1'b0;
      lrclk_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      mph_reg   <= mph_next;
      sph_reg   <= sph_next;
      slot_reg  <= slot_next;
      mclk_reg  <= go && (mph_next >= MPH_HALF);
      sclk_reg  <= go && (sph_next >= SPH_HALF);
      lrclk_reg <= go && slot_next[SLOT_W-1];
    end
  end

  assign cnt   = cnt_reg;
  assign mclk  = mclk_reg;
  assign sclk  = sclk_reg;
  assign lrclk = lrclk_reg;

endmodule

// File: rtl/audio_i2s_tx_ctrl.sv
// I2S transmitter: one-deep stereo holding register feeding a 64-slot frame
// shifter, with IDLE/RUN/STOP control that only stops on frame boundaries.
module audio_i2s_tx_ctrl
  import audio_pkg::*;
#(
  parameter int MCLK_DIV   = 8,
  parameter int BCLK_RATIO = 4,
  parameter int SAMPLE_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                mclk,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME = frame_cycles(MCLK_DIV, BCLK_RATIO);
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  tx_state_t state_reg, state_next;

  logic [CNT_W-1:0]    cnt;
  logic                running, go, sclk_fall, frame0, last_cycle;
  logic                hold_full_reg;
  logic [SAMPLE_W-1:0] hold_left_reg, hold_right_reg;
  logic [SLOTS-1:0]    shift_reg;
  logic                sdata_reg, frame_start_reg, underrun_reg;
  logic [SAMPLE_W-1:0] ld_left, ld_right;
  logic                ld_valid;
  logic [SLOTS:0]      frame_word;

  audio_clk_phase #(
    .MCLK_DIV   (MCLK_DIV),
    .BCLK_RATIO (BCLK_RATIO),
    .CNT_W      (CNT_W)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .running   (running),
    .go        (go),
    .cnt       (cnt),
    .mclk      (mclk),
    .sclk      (sclk),
    .lrclk     (lrclk),
    .sclk_fall (sclk_fall),
    .frame0    (frame0)
  );

  assign last_cycle = (cnt == CNT_LAST);

  // Dropping enable on the very last cycle of a frame goes straight to IDLE,
  // so STOP never spans a frame that was never loaded.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable) state_next = ST_RUN;
      ST_RUN:  if (!enable) state_next = last_cycle ? ST_IDLE : ST_STOP;
      ST_STOP: begin
        if (enable)          state_next = ST_RUN;
        else if (last_cycle) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign running = (state_reg != ST_IDLE);
  assign go      = (state_next != ST_IDLE);

  // Load source: held sample first, else a sample handshaking on this edge.
  always_comb begin
    ld_left  = '0;
    ld_right = '0;
    ld_valid = 1'b0;
    if (hold_full_reg) begin
      ld_left  = hold_left_reg;
      ld_right = hold_right_reg;
      ld_valid = 1'b1;
    end else if (s_valid) begin
      ld_left  = s_left;
      ld_right = s_right;
      ld_valid = 1'b1;
    end
  end

  // Slot g of the frame sits at bit SLOTS-g; each word starts one slot after
  // its lrclk edge. The extra bit 0 is a word spilling past slot 63, dropped.
  for (genvar gi = 0; gi <= SLOTS; gi++) begin : g_slot
    if (gi >= 1 && gi <= SAMPLE_W) begin : g_left
      assign frame_word[SLOTS-gi] = ld_left[SAMPLE_W-gi];
    end else if (gi >= SLOT_BITS + 1 && gi <= SLOT_BITS + SAMPLE_W) begin : g_right
      assign frame_word[SLOTS-gi] = ld_right[SAMPLE_W-(gi-SLOT_BITS)];
    end else begin : g_zero
      assign frame_word[SLOTS-gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      hold_full_reg   <= 1'b0;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      shift_reg       <= '0;
      sdata_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;

      if (frame0) begin
        frame_start_reg <= 1'b1;
        underrun_reg    <= !ld_valid;
        hold_full_reg   <= 1'b0;
      end else if (s_valid && !hold_full_reg) begin
        hold_full_reg  <= 1'b1;
        hold_left_reg  <= s_left;
        hold_right_reg <= s_right;
      end

      if (!go) begin
        sdata_reg <= 1'b0;
        shift_reg <= '0;
      end else if (frame0) begin
        sdata_reg <= frame_word[SLOTS];
        shift_reg <= frame_word[SLOTS-1:0];
      end else if (sclk_fall) begin
        sdata_reg <= shift_reg[SLOTS-1];
        shift_reg <= {shift_reg[SLOTS-2:0], 1'b0};
      end
    end
  end

  assign s_ready     = !hold_full_reg;
  assign sdata       = sdata_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule
